// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - receive-side byte/status bundle from the UART front end
`timescale 1ns/1ps
interface uart_rx_frontend_if;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       idle;
    logic       eof;
    logic [3:0] bit_count;

    modport master (
        output data, valid, frame_err, busy, idle, eof, bit_count
    );

    modport slave (
        input data, valid, frame_err, busy, idle, eof, bit_count
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 UART receiver with framing, idle and end-of-burst reporting
`timescale 1ns/1ps
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int IDLE_BITS    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    uart_rx_frontend_if.master rx_if
);
    localparam int HALF     = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int ICNT_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(ICNT_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [IW-1:0] ICNT_SAT = IW'(ICNT_MAX);
    localparam logic [IW-1:0] ICNT_PRE = IW'(ICNT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic          s1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [IW-1:0] icnt;
    logic [7:0]    shreg;
    logic          got;
    logic          idle_nxt;
    logic          eof_fire;

    // idle is registered, so look one count ahead to make it rise exactly at saturation
    assign idle_nxt = (state == S_IDLE) && rx_s && (icnt >= ICNT_PRE);
    assign eof_fire = got && !rx_if.idle && idle_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            s1              <= 1'b1;
            rx_s            <= 1'b1;
            cnt             <= '0;
            icnt            <= '0;
            shreg           <= '0;
            got             <= 1'b0;
            rx_if.data      <= 8'h00;
            rx_if.valid     <= 1'b0;
            rx_if.frame_err <= 1'b0;
            rx_if.busy      <= 1'b0;
            rx_if.idle      <= 1'b0;
            rx_if.eof       <= 1'b0;
            rx_if.bit_count <= 4'd0;
        end else begin
            s1              <= rx;
            rx_s            <= s1;
            rx_if.valid     <= 1'b0;
            rx_if.frame_err <= 1'b0;
            rx_if.idle      <= idle_nxt;
            rx_if.eof       <= eof_fire;

            if (state == S_IDLE && rx_s) begin
                if (icnt != ICNT_SAT) begin
                    icnt <= icnt + 1'b1;
                end
            end else begin
                icnt <= '0;
            end

            if (eof_fire) begin
                got <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state      <= S_START;
                        cnt        <= '0;
                        rx_if.busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state           <= S_DATA;
                            rx_if.bit_count <= 4'd0;
                        end else begin
                            state      <= S_IDLE;
                            rx_if.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt             <= '0;
                        shreg           <= {rx_s, shreg[7:1]};
                        rx_if.bit_count <= rx_if.bit_count + 4'd1;
                        if (rx_if.bit_count == 4'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_if.data  <= shreg;
                            rx_if.valid <= 1'b1;
                            got         <= 1'b1;
                            state       <= S_IDLE;
                            rx_if.busy  <= 1'b0;
                        end else begin
                            rx_if.frame_err <= 1'b1;
                            state           <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // a line held low after a bad stop bit must not look like a new start bit
                    if (rx_s) begin
                        state      <= S_IDLE;
                        rx_if.busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    rx_if.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
